argmax_accuracy_scorer: RTL and testbench

//   Parametrised on-chip scorer for classifier outputs. Accepts one packed vector of NUM_CLASSES

---
 rtl/argmax_accuracy_scorer.sv | 128 ++++++++++++
 tb/tb_argmax_accuracy_scorer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_accuracy_scorer.sv
// argmax_accuracy_scorer: serial sign-magnitude argmax with running accuracy counters.
// Define CONFUSION_MATRIX_EN to add a [label][pred] confusion matrix with combinational read port.
module argmax_accuracy_scorer #(
    parameter int BITSIZE     = 20,
    parameter int NUM_CLASSES = 2,
    parameter int CNT_W       = 16,
    parameter int LABEL_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BITSIZE*NUM_CLASSES-1:0] scores,
    input  logic [LABEL_W-1:0]             label,
    output logic                           out_valid,
    output logic [LABEL_W-1:0]             pred_class,
    output logic                           correct,
    output logic                           label_err,
    output logic [CNT_W-1:0]               total_cnt,
    output logic [CNT_W-1:0]               correct_cnt
`ifdef CONFUSION_MATRIX_EN
    ,
    input  logic [LABEL_W-1:0]             conf_rd_row,
    input  logic [LABEL_W-1:0]             conf_rd_col,
    output logic [CNT_W-1:0]               conf_rd_data
`endif
);
    localparam int SW = BITSIZE * NUM_CLASSES;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nx;

    logic [SW-1:0]      sbuf;
    logic [BITSIZE-1:0] best, cand;
    logic [LABEL_W-1:0] idx, best_idx, label_q;
    logic               last, lerr, hit;

    // Map sign-magnitude onto a signed value so -0 and +0 compare equal.
    function automatic logic signed [BITSIZE:0] key(input logic [BITSIZE-1:0] s);
        return s[BITSIZE-1] ? -$signed({2'b00, s[BITSIZE-2:0]}) : $signed({2'b00, s[BITSIZE-2:0]});
    endfunction

    // Remaining scores are shifted up so the candidate is always in the top slot.
    assign cand = sbuf[SW-1 -: BITSIZE];
    assign last = idx == LABEL_W'(NUM_CLASSES - 1);
    assign lerr = int'(label_q) >= NUM_CLASSES;
    assign hit  = !lerr && best_idx == label_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (in_valid ? SCAN : IDLE) :
                   state == SCAN ? (last ? DONE : SCAN) : IDLE;

    always_comb
        in_ready = state == IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sbuf       <= '0;
            best       <= '0;
            idx        <= '0;
            best_idx   <= '0;
            label_q    <= '0;
            out_valid  <= 1'b0;
            pred_class <= '0;
            correct    <= 1'b0;
            label_err  <= 1'b0;
        end else begin
            out_valid <= state == DONE;
            if (state == IDLE && in_valid) begin
                sbuf     <= scores << BITSIZE;
                best     <= scores[SW-1 -: BITSIZE];
                idx      <= LABEL_W'(1);
                best_idx <= '0;
                label_q  <= label;
            end
            if (state == SCAN) begin
                sbuf <= sbuf << BITSIZE;
                idx  <= idx + LABEL_W'(1);
                if (key(cand) > key(best)) begin
                    best     <= cand;
                    best_idx <= idx;
                end
            end
            if (state == DONE) begin
                pred_class <= best_idx;
                correct    <= hit;
                label_err  <= lerr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
        end else if (clear) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
        end else if (state == DONE) begin
            if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
            if (hit && correct_cnt != '1) correct_cnt <= correct_cnt + CNT_W'(1);
        end
    end

`ifdef CONFUSION_MATRIX_EN
    logic [CNT_W-1:0] conf [NUM_CLASSES][NUM_CLASSES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                for (int j = 0; j < NUM_CLASSES; j++) conf[i][j] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                for (int j = 0; j < NUM_CLASSES; j++) conf[i][j] <= '0;
        end else if (state == DONE && !lerr && conf[label_q][best_idx] != '1) begin
            conf[label_q][best_idx] <= conf[label_q][best_idx] + CNT_W'(1);
        end
    end

    assign conf_rd_data = (int'(conf_rd_row) < NUM_CLASSES && int'(conf_rd_col) < NUM_CLASSES) ?
                          conf[conf_rd_row][conf_rd_col] : '0;
`endif
endmodule

// File: tb/tb_argmax_accuracy_scorer.sv
// tb_argmax_accuracy_scorer: directed vector table over N=2, N=4 and N=3/CNT_W=4 instances.
module tb_argmax_accuracy_scorer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [79:0] scores = '0;
    logic [1:0]  label = '0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic        v2, v4, v3, r2, r4, r3, o2, o4, o3, c2, c4, c3, e2, e4, e3;
    logic [0:0]  p2;
    logic [1:0]  p4, p3;
    logic [15:0] t2, t4, k2, k4;
    logic [3:0]  t3, k3;
    logic        rdy, ov, cor, err;
    logic [1:0]  pred;
    logic [15:0] tot, cc;

    always #5 clk = ~clk;

    assign v2 = in_valid && sel == 0;
    assign v4 = in_valid && sel == 1;
    assign v3 = in_valid && sel == 2;

    always_comb begin
        rdy  = sel == 0 ? r2 : sel == 1 ? r4 : r3;
        ov   = sel == 0 ? o2 : sel == 1 ? o4 : o3;
        cor  = sel == 0 ? c2 : sel == 1 ? c4 : c3;
        err  = sel == 0 ? e2 : sel == 1 ? e4 : e3;
        pred = sel == 0 ? {1'b0, p2} : sel == 1 ? p4 : p3;
        tot  = sel == 0 ? t2 : sel == 1 ? t4 : {12'd0, t3};
        cc   = sel == 0 ? k2 : sel == 1 ? k4 : {12'd0, k3};
    end

`ifdef CONFUSION_MATRIX_EN
    logic [15:0] cd2, cd4;
    logic [3:0]  cd3;
`endif

    argmax_accuracy_scorer #(.BITSIZE(20), .NUM_CLASSES(2), .CNT_W(16)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(v2), .in_ready(r2),
        .scores(scores[39:0]), .label(label[0:0]), .out_valid(o2), .pred_class(p2),
        .correct(c2), .label_err(e2), .total_cnt(t2), .correct_cnt(k2)
`ifdef CONFUSION_MATRIX_EN
        , .conf_rd_row(1'b0), .conf_rd_col(1'b0), .conf_rd_data(cd2)
`endif
    );

    argmax_accuracy_scorer #(.BITSIZE(20), .NUM_CLASSES(4), .CNT_W(16)) d4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(v4), .in_ready(r4),
        .scores(scores), .label(label), .out_valid(o4), .pred_class(p4),
        .correct(c4), .label_err(e4), .total_cnt(t4), .correct_cnt(k4)
`ifdef CONFUSION_MATRIX_EN
        , .conf_rd_row(2'd0), .conf_rd_col(2'd0), .conf_rd_data(cd4)
`endif
    );

    argmax_accuracy_scorer #(.BITSIZE(20), .NUM_CLASSES(3), .CNT_W(4)) d3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(v3), .in_ready(r3),
        .scores(scores[59:0]), .label(label), .out_valid(o3), .pred_class(p3),
        .correct(c3), .label_err(e3), .total_cnt(t3), .correct_cnt(k3)
`ifdef CONFUSION_MATRIX_EN
        , .conf_rd_row(2'd0), .conf_rd_col(2'd0), .conf_rd_data(cd3)
`endif
    );

    typedef struct {
        int          d;
        logic [79:0] sc;
        logic [1:0]  lb;
        logic [1:0]  pred;
        logic        cor;
        logic        err;
        logic [15:0] tot;
        logic [15:0] cc;
    } vec_t;

    vec_t vt[10];
    localparam logic [19:0] NZ = 20'h80000;

    function automatic logic [19:0] sm(input int x);
        return x < 0 ? {1'b1, 19'(-x)} : {1'b0, 19'(x)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input bit full);
        int n, low, nc;
        sel    = v.d;
        nc     = v.d == 0 ? 2 : v.d == 1 ? 4 : 3;
        scores = v.sc;
        label  = v.lb;
        if (full) check("ready_before", 32'(rdy), 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        low = 0;
        do begin
            if (!rdy) low++;
            @(posedge clk);
            #1 n++;
        end while (!ov && n < 20);
        check("out_valid_seen", 32'(ov), 1);
        if (full) begin
            check("latency", n, nc);
            check("ready_low_cycles", low, nc);
            check("pred_class", 32'(pred), 32'(v.pred));
            check("correct", 32'(cor), 32'(v.cor));
            check("label_err", 32'(err), 32'(v.err));
            check("total_cnt", 32'(tot), 32'(v.tot));
            check("correct_cnt", 32'(cc), 32'(v.cc));
        end
        @(posedge clk);
        #1;
        if (full) check("out_valid_one_cycle", 32'(ov), 0);
    endtask

    initial begin
        vt[0] = '{0, {40'd0, sm(5), sm(-3)}, 2'd0, 2'd0, 1'b1, 1'b0, 16'd1, 16'd1};
        vt[1] = '{0, {40'd0, sm(-7), sm(-2)}, 2'd1, 2'd1, 1'b1, 1'b0, 16'd2, 16'd2};
        vt[2] = '{0, {40'd0, NZ, sm(0)}, 2'd1, 2'd0, 1'b0, 1'b0, 16'd3, 16'd2};
        vt[3] = '{0, {40'd0, sm(1), sm(4)}, 2'd0, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vt[4] = '{1, {sm(3), sm(9), sm(9), sm(-1)}, 2'd2, 2'd1, 1'b0, 1'b0, 16'd1, 16'd0};
        vt[5] = '{1, {sm(-5), sm(-1), sm(-9), sm(-2)}, 2'd1, 2'd1, 1'b1, 1'b0, 16'd2, 16'd1};
        vt[6] = '{1, {sm(-1), sm(0), NZ, sm(2)}, 2'd3, 2'd3, 1'b1, 1'b0, 16'd3, 16'd2};
        vt[7] = '{2, {20'd0, sm(1), sm(2), sm(3)}, 2'd2, 2'd2, 1'b1, 1'b0, 16'd1, 16'd1};
        vt[8] = '{2, {20'd0, sm(1), sm(2), sm(3)}, 2'd3, 2'd2, 1'b0, 1'b1, 16'd2, 16'd1};
        vt[9] = '{2, {20'd0, sm(8), sm(-8), sm(0)}, 2'd0, 2'd0, 1'b1, 1'b0, 16'd3, 16'd2};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check("reset_in_ready", 32'(rdy), 1);
            check("reset_out_valid", 32'(ov), 0);
            check("reset_pred", 32'(pred), 0);
            check("reset_total", 32'(tot), 0);
            check("reset_correct_cnt", 32'(cc), 0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) run(vt[i], 1'b1);

        // clear during DONE on the N=2 instance: counters zero, result not counted
        sel = 0;
        scores = {40'd0, sm(5), sm(-3)};
        label = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_done_out_valid", 32'(ov), 1);
        check("clear_done_total", 32'(tot), 0);
        check("clear_done_correct_cnt", 32'(cc), 0);
        check("clear_done_pred", 32'(pred), 0);
        @(posedge clk);
        #1;

        for (int i = 4; i < 10; i++) run(vt[i], 1'b1);

        for (int i = 0; i < 20; i++) run(vt[7], 1'b0);
        check("sat_total", 32'(tot), 15);
        check("sat_correct_cnt", 32'(cc), 15);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_total", 32'(tot), 0);
        check("clear_correct_cnt", 32'(cc), 0);

        // async reset mid-scan on the N=4 instance
        run(vt[6], 1'b0);
        sel = 1;
        scores = {sm(3), sm(9), sm(9), sm(-1)};
        label = 2'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midreset_in_ready", 32'(rdy), 1);
        check("midreset_out_valid", 32'(ov), 0);
        check("midreset_pred", 32'(pred), 0);
        check("midreset_correct", 32'(cor), 0);
        check("midreset_total", 32'(tot), 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        run('{1, {sm(3), sm(9), sm(9), sm(-1)}, 2'd1, 2'd1, 1'b1, 1'b0, 16'd1, 16'd1}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
